// File: rtl/conv_pkg.sv
// Shared definitions for the convolution block family: sequencer state
// encoding and the default downstream pipeline latencies.
package conv_pkg;

  localparam int DEF_WT_LATENCY      = 3;
  localparam int DEF_CONV_PE_PIPE    = 4;
  localparam int DEF_QUANT_LATENCY   = 4;
  localparam int DEF_MAXPOOL_LATENCY = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BIAS,
    S_WAIT_BIAS,
    S_CONV,
    S_DRAIN,
    S_NEXT
  } seq_state_e;

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Data-path handshakes between the layer sequencer and the bias store,
// weight manager, pixel stream and conv_3x3 array.
interface conv_layer_sequencer_if #(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7
);

  logic                       bias_rd_en;
  logic [BIAS_ADDR_WIDTH-1:0] bias_rd_group;
  logic                       bias_valid;
  logic                       wt_rd_en;
  logic [WT_ADDR_WIDTH-1:0]   wt_rd_addr;
  logic                       frame_start;
  logic                       pixel_valid;
  logic                       pixel_ready;
  logic                       last_pixel;
  logic                       conv_valid_in;
  logic                       conv_last_channel;

  modport master (
    output bias_rd_en, bias_rd_group, wt_rd_en, wt_rd_addr, frame_start,
           pixel_ready, conv_valid_in, conv_last_channel,
    input  bias_valid, pixel_valid, last_pixel
  );

  modport slave (
    input  bias_rd_en, bias_rd_group, wt_rd_en, wt_rd_addr, frame_start,
           pixel_ready, conv_valid_in, conv_last_channel,
    output bias_valid, pixel_valid, last_pixel
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that carries flags alongside the weight read
// latency so they reach conv_3x3 together with the weights.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the head, so an aborted layer
  // cannot leak stale valids into conv_3x3 after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs a full convolution layer from one go: per output group it loads the
// bias, replays the pixel stream and walks the weight addresses.
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_ADDR_WIDTH = 7,
  parameter int CI_WIDTH        = 10,
  parameter int WT_LATENCY      = DEF_WT_LATENCY,
  parameter int CONV_PE_PIPE    = DEF_CONV_PE_PIPE,
  parameter int QUANT_LATENCY   = DEF_QUANT_LATENCY,
  parameter int MAXPOOL_LATENCY = DEF_MAXPOOL_LATENCY,
  parameter int PIPE_DEPTH      = WT_LATENCY + CONV_PE_PIPE + 1 + QUANT_LATENCY + MAXPOOL_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CI_WIDTH-1:0]        cfg_ci_groups,
  input  logic [BIAS_ADDR_WIDTH-1:0] cfg_co_groups,
  input  logic [BIAS_ADDR_WIDTH-1:0] cfg_bias_base,
  input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base_addr,
  input  logic                       cfg_maxpool_en,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  output logic                       group_done,
  output logic [BIAS_ADDR_WIDTH-1:0] cur_group,
  conv_layer_sequencer_if.master     bus
);

  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

  seq_state_e state_q, state_d;

  // Layer configuration captured at go
  logic [CI_WIDTH-1:0]        ci_eff_q;
  logic [BIAS_ADDR_WIDTH-1:0] co_last_q;
  logic                       co_zero_q;
  logic [BIAS_ADDR_WIDTH-1:0] bias_base_q;
  logic [DRAIN_W-1:0]         drain_last_q;

  logic [CI_WIDTH-1:0]        ci_cnt_q;
  logic [WT_ADDR_WIDTH-1:0]   grp_base_q;
  logic [DRAIN_W-1:0]         drain_cnt_q;
  logic [WT_ADDR_WIDTH-1:0]   wt_rd_addr_q;
  logic bias_rd_en_q, frame_start_q, wt_rd_en_q, wt_last_q;
  logic [1:0] aligned;

  logic go_accept, beat, last_ch, drain_end, last_group, layer_end;

  // A go landing on the done cycle is ignored, hence the !done term.
  assign go_accept  = (state_q == S_IDLE) && go && !done;
  assign beat       = (state_q == S_CONV) && bus.pixel_valid;
  assign last_ch    = (ci_cnt_q == ci_eff_q - CI_WIDTH'(1));
  assign drain_end  = (state_q == S_DRAIN) && (drain_cnt_q == drain_last_q);
  assign last_group = (cur_group == co_last_q);
  assign layer_end  = ((state_q == S_LOAD_BIAS) && co_zero_q) || (drain_end && last_group);

  always_comb begin
    // NOTE: state_d takes its hold value before the case so paths that do
    // not assign it cannot infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (go_accept) state_d = S_LOAD_BIAS;
      S_LOAD_BIAS: state_d = co_zero_q ? S_IDLE : S_WAIT_BIAS;
      S_WAIT_BIAS: if (bus.bias_valid) state_d = S_CONV;
      S_CONV:      if (beat && last_ch && bus.last_pixel) state_d = S_DRAIN;
      S_DRAIN:     if (drain_end) state_d = last_group ? S_IDLE : S_NEXT;
      S_NEXT:      state_d = S_LOAD_BIAS;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below updates with <= so every reader in this block sees
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      group_done    <= 1'b0;
      cur_group     <= '0;
      bias_rd_en_q  <= 1'b0;
      frame_start_q <= 1'b0;
      wt_rd_en_q    <= 1'b0;
      wt_last_q     <= 1'b0;
      wt_rd_addr_q  <= '0;
      ci_cnt_q      <= '0;
      grp_base_q    <= '0;
      drain_cnt_q   <= '0;
      ci_eff_q      <= '0;
      co_last_q     <= '0;
      co_zero_q     <= 1'b0;
      bias_base_q   <= '0;
      drain_last_q  <= '0;
    end else begin
      state_q       <= state_d;
      done          <= layer_end;
      group_done    <= drain_end;
      bias_rd_en_q  <= (state_q == S_LOAD_BIAS) && !co_zero_q;
      frame_start_q <= (state_q == S_WAIT_BIAS) && bus.bias_valid;
      wt_rd_en_q    <= beat;
      wt_last_q     <= beat && last_ch;
      drain_cnt_q   <= (state_q == S_DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;

      if (go_accept)      busy <= 1'b1;
      else if (layer_end) busy <= 1'b0;

      if (go_accept) begin
        ci_eff_q     <= (cfg_ci_groups == '0) ? CI_WIDTH'(1) : cfg_ci_groups;
        co_last_q    <= cfg_co_groups - BIAS_ADDR_WIDTH'(1);
        co_zero_q    <= (cfg_co_groups == '0);
        bias_base_q  <= cfg_bias_base;
        drain_last_q <= cfg_maxpool_en ? DRAIN_W'(PIPE_DEPTH - 1)
                                       : DRAIN_W'(PIPE_DEPTH - MAXPOOL_LATENCY - 1);
        cur_group    <= '0;
        grp_base_q   <= cfg_wt_base_addr;
        ci_cnt_q     <= '0;
      end

      if (beat) begin
        wt_rd_addr_q <= grp_base_q + WT_ADDR_WIDTH'(ci_cnt_q);
        ci_cnt_q     <= last_ch ? '0 : ci_cnt_q + CI_WIDTH'(1);
      end

      // Per-group weight base is accumulated rather than multiplied out.
      if (state_q == S_NEXT) begin
        cur_group  <= cur_group + BIAS_ADDR_WIDTH'(1);
        grp_base_q <= grp_base_q + WT_ADDR_WIDTH'(ci_eff_q);
      end
    end
  end

  valid_delay_line #(
    .DEPTH (WT_LATENCY),
    .WIDTH (2)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  ({wt_rd_en_q, wt_last_q}),
    .dout (aligned)
  );

  assign bus.bias_rd_en        = bias_rd_en_q;
  assign bus.bias_rd_group     = bias_base_q + cur_group;
  assign bus.wt_rd_en          = wt_rd_en_q;
  assign bus.wt_rd_addr        = wt_rd_addr_q;
  assign bus.frame_start       = frame_start_q;
  assign bus.pixel_ready       = (state_q == S_CONV);
  assign bus.conv_valid_in     = aligned[1];
  assign bus.conv_last_channel = aligned[0];

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: a transaction-level layer model predicts every pulse
// and address by cycle number; a negedge monitor compares the DUT each cycle.
module tb_conv_layer_sequencer;

  localparam int WT_LAT     = 3;
  localparam int MP_LAT     = 4;
  localparam int PIPE_DEPTH = 3 + 4 + 1 + 4 + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cfg_ci_groups = '0;
  logic [6:0]  cfg_co_groups = '0;
  logic [6:0]  cfg_bias_base = '0;
  logic [11:0] cfg_wt_base_addr = '0;
  logic        cfg_maxpool_en = 1'b0;
  logic        go = 1'b0;
  logic        busy, done, group_done;
  logic [6:0]  cur_group;

  conv_layer_sequencer_if bus ();

  conv_layer_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_ci_groups    (cfg_ci_groups),
    .cfg_co_groups    (cfg_co_groups),
    .cfg_bias_base    (cfg_bias_base),
    .cfg_wt_base_addr (cfg_wt_base_addr),
    .cfg_maxpool_en   (cfg_maxpool_en),
    .go               (go),
    .busy             (busy),
    .done             (done),
    .group_done       (group_done),
    .cur_group        (cur_group),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
  endtask

  // Expected events keyed by cycle number
  int exp_wt[int];
  bit exp_cv[int];
  int exp_bias[int];
  int exp_grp[int];
  bit exp_fs[int];
  bit exp_gd[int];
  bit exp_done[int];
  bit exp_rdy[int];
  int busy_start = 0;
  int busy_end   = 0;
  bit mon_en     = 1'b0;
  int last_done_cyc = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      check("wt_rd_en", bus.wt_rd_en, exp_wt.exists(cyc));
      if (exp_wt.exists(cyc)) check("wt_rd_addr", bus.wt_rd_addr, exp_wt[cyc]);
      check("conv_valid_in", bus.conv_valid_in, exp_cv.exists(cyc));
      check("conv_last_channel", bus.conv_last_channel, exp_cv.exists(cyc) ? exp_cv[cyc] : 1'b0);
      check("bias_rd_en", bus.bias_rd_en, exp_bias.exists(cyc));
      if (exp_bias.exists(cyc)) begin
        check("bias_rd_group", bus.bias_rd_group, exp_bias[cyc]);
        check("cur_group", cur_group, exp_grp[cyc]);
      end
      check("frame_start", bus.frame_start, exp_fs.exists(cyc));
      check("pixel_ready", bus.pixel_ready, exp_rdy.exists(cyc));
      check("group_done", group_done, exp_gd.exists(cyc));
      check("done", done, exp_done.exists(cyc));
      check("busy", busy, (cyc >= busy_start) && (cyc < busy_end));
      if (done) last_done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.pixel_valid = 1'($urandom_range(1));
    bus.last_pixel  = 1'($urandom_range(1));
  endtask

  task automatic scramble_cfg();
    cfg_ci_groups    = 10'($urandom);
    cfg_co_groups    = 7'($urandom);
    cfg_bias_base    = 7'($urandom);
    cfg_wt_base_addr = 12'($urandom);
    cfg_maxpool_en   = 1'($urandom);
  endtask

  // One layer: model computes, from the configuration and the stimulus it
  // chooses, the cycle of every expected output event.
  task automatic run_layer(input int ci, input int co, input int bb, input int wb,
                           input int mp, input int ppf, input int bdly, input int vpct,
                           input bit go_noise, output int t_go);
    int eff, drain, tb, tbv, tlast, tgd, k, total, ch, pix;
    eff   = (ci == 0) ? 1 : ci;
    drain = mp ? PIPE_DEPTH : PIPE_DEPTH - MP_LAT;
    bus.bias_valid = 1'b0;
    cfg_ci_groups    = ci[9:0];
    cfg_co_groups    = co[6:0];
    cfg_bias_base    = bb[6:0];
    cfg_wt_base_addr = wb[11:0];
    cfg_maxpool_en   = mp[0];
    go   = 1'b1;
    t_go = cyc;
    busy_start = t_go + 1;
    busy_end   = 32'h3fff_ffff;
    noise();
    step();
    go = 1'b0;
    scramble_cfg();
    if (co == 0) begin
      exp_done[t_go + 2] = 1'b1;
      busy_end = t_go + 2;
      noise();
      step();
      go = 1'b1;
      step();
      go = 1'b0;
      step();
      step();
      return;
    end
    tb = t_go + 2;
    tgd = 0;
    for (int g = 0; g < co; g++) begin
      exp_bias[tb] = (bb + g) % 128;
      exp_grp[tb]  = g;
      tbv = tb + bdly;
      while (cyc < tbv) begin
        noise();
        step();
      end
      bus.bias_valid = 1'b1;
      exp_fs[tbv + 1] = 1'b1;
      noise();
      step();
      bus.bias_valid = 1'b0;
      k = 0;
      total = eff * ppf;
      tlast = 0;
      while (k < total) begin
        exp_rdy[cyc] = 1'b1;
        if ($urandom_range(99) < vpct) begin
          ch  = k % eff;
          pix = k / eff;
          bus.pixel_valid = 1'b1;
          bus.last_pixel  = (pix == ppf - 1);
          exp_wt[cyc + 1] = (wb + g * eff + ch) % 4096;
          exp_cv[cyc + 1 + WT_LAT] = (ch == eff - 1);
          if (k == total - 1) tlast = cyc;
          k++;
        end else begin
          bus.pixel_valid = 1'b0;
          bus.last_pixel  = 1'($urandom_range(1));
        end
        go = go_noise && ($urandom_range(3) == 0);
        step();
      end
      go = 1'b0;
      tgd = tlast + 1 + drain;
      exp_gd[tgd] = 1'b1;
      if (g == co - 1) begin
        exp_done[tgd] = 1'b1;
        busy_end = tgd;
      end
      while (cyc < tgd) begin
        noise();
        step();
      end
      tb = tgd + 2;
    end
    // go coincident with done must be ignored
    bus.pixel_valid = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_group_done"}, group_done, 0);
    check({pfx, "_cur_group"}, cur_group, 0);
    check({pfx, "_bias_rd_en"}, bus.bias_rd_en, 0);
    check({pfx, "_bias_rd_group"}, bus.bias_rd_group, 0);
    check({pfx, "_wt_rd_en"}, bus.wt_rd_en, 0);
    check({pfx, "_wt_rd_addr"}, bus.wt_rd_addr, 0);
    check({pfx, "_frame_start"}, bus.frame_start, 0);
    check({pfx, "_pixel_ready"}, bus.pixel_ready, 0);
    check({pfx, "_conv_valid_in"}, bus.conv_valid_in, 0);
    check({pfx, "_conv_last_channel"}, bus.conv_last_channel, 0);
  endtask

  task automatic clear_model();
    exp_wt.delete();
    exp_cv.delete();
    exp_bias.delete();
    exp_grp.delete();
    exp_fs.delete();
    exp_gd.delete();
    exp_done.delete();
    exp_rdy.delete();
    busy_start = 0;
    busy_end   = 0;
  endtask

  // Abort mid-CONV with weight reads and aligned valids in flight.
  task automatic reset_abort();
    mon_en = 1'b0;
    cfg_ci_groups    = 10'd2;
    cfg_co_groups    = 7'd2;
    cfg_bias_base    = 7'd3;
    cfg_wt_base_addr = 12'h040;
    cfg_maxpool_en   = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    bus.bias_valid  = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.last_pixel  = 1'b0;
    step();
    step();
    check("abort_pre_ready", bus.pixel_ready, 1);
    bus.bias_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    check_zero("abort");
    for (int i = 0; i < WT_LAT + 1; i++) begin
      @(negedge clk);
      check("abort_flush_valid", bus.conv_valid_in, 0);
      check("abort_flush_busy", busy, 0);
    end
    step();
    clear_model();
    mon_en = 1'b1;
  endtask

  initial begin
    int t_go, d_on, d_off;
    bus.bias_valid  = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.last_pixel  = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_zero("reset");
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    step();

    run_layer(4, 1, 0, 'h100, 1, 2, 0, 100, 1'b0, t_go);
    run_layer(3, 3, 5, 0, 1, 1, 2, 100, 1'b0, t_go);
    run_layer(3, 2, 9, 'h200, 1, 2, 7, 50, 1'b1, t_go);

    run_layer(2, 1, 0, 0, 1, 1, 0, 100, 1'b0, t_go);
    d_on = last_done_cyc - t_go;
    run_layer(2, 1, 0, 0, 0, 1, 0, 100, 1'b0, t_go);
    d_off = last_done_cyc - t_go;
    check("maxpool_bypass_saving", d_on - d_off, 4);

    run_layer(4, 0, 0, 'h300, 1, 1, 0, 100, 1'b0, t_go);
    check("co_zero_done_latency", last_done_cyc - t_go, 2);
    run_layer(0, 2, 1, 'h010, 1, 2, 1, 70, 1'b0, t_go);
    run_layer(4, 3, 126, 'hFFE, 0, 1, 3, 100, 1'b0, t_go);

    reset_abort();
    run_layer(2, 2, 3, 'h040, 1, 2, 1, 80, 1'b1, t_go);

    for (int r = 0; r < 8; r++) begin
      run_layer($urandom_range(5), $urandom_range(3), $urandom_range(127),
                $urandom_range(4095), $urandom_range(1), $urandom_range(3, 1),
                $urandom_range(7), $urandom_range(100, 30), 1'b1, t_go);
    end

    repeat (4) step();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
